io_out_uart_tx: RTL and testbench
=================================

// Module: io_out_uart_tx
// PURPOSE
//  Output-port stage downstream of the 8-bit CPU core. Captures each byte the CPU writes to its
//  output port (OUT instructions), buffers it in a small FIFO, and serialises it as 8N1 UART on tx.
//  Lets the CPU issue OUT back-to-back without waiting for the serial line; drops are flagged.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per UART bit; legal >= 2
//  FIFO_DEPTH    8   FIFO entries; power of two, >= 2
// PORTS
//  clk         in   1               system clock, all logic on posedge
//  rst         in   1               asynchronous, active-low reset (0 = reset)
//  out_data    in   8               byte from the CPU output register
//  out_we      in   1               1-cycle strobe: push out_data
//  out_full    out  1               FIFO holds FIFO_DEPTH entries
//  fifo_count  out  $clog2(D)+1     current FIFO occupancy
//  tx          out  1               UART serial line, idle high
//  busy        out  1               1 while a frame is being shifted (state != IDLE)
//  overflow    out  1               sticky: a push was dropped
//  ovf_clr     in   1               clears overflow
// BEHAVIOUR
//  Reset (rst=0, async): tx=1, busy=0, fifo_count=0, out_full=0, overflow=0, FSM=IDLE.
//  Reset also clears the FIFO pointers. A frame in flight is abandoned and tx goes high at once.
//  FIFO push: on a posedge with out_we=1 and out_full=0, out_data is written at wr_ptr.
//  The push raises fifo_count on that edge. Pointers wrap modulo FIFO_DEPTH.
//  Push while out_full=1: the byte is dropped and overflow<=1. This holds even if a pop
//  happens on the same edge; out_full is the pre-edge value.
//  Push and pop on the same edge (not full): both take effect and fifo_count is unchanged.
//  Overflow set and ovf_clr on the same edge: set wins.
//  FSM states: IDLE, START, DATA, STOP. Counters: baud_cnt (0..CLKS_PER_BIT-1), bit_idx (0..7).
//  IDLE: tx=1. If fifo_count!=0, pop the head into shift_reg, set baud_cnt=0, and go to START.
//    A byte pushed at edge N into an empty FIFO is popped at edge N+1.
//    tx falls after edge N+1, so latency from push to start bit is 1 cycle.
//  START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
//  DATA: tx=shift_reg[0] (LSB first). Each bit is held CLKS_PER_BIT cycles, then
//    shift_reg>>=1 and bit_idx++. After bit 7, go to STOP.
//  STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
//  Back-to-back bytes: one IDLE cycle between frames. Frame period = 10*CLKS_PER_BIT+1 cycles.
//  tx and busy are registered (no glitches). busy=1 from the pop edge until the STOP->IDLE edge.
//  out_data is sampled only on the push edge; later changes to it do not affect queued bytes.
//  Empty FIFO in IDLE: nothing happens and tx stays 1 indefinitely.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=8)
//  1. Push 0xA5 from idle.
//     -> tx: start 0, then 1,0,1,0,0,1,0,1, then stop 1. Each level lasts 4 cycles.
//     -> start bit begins 1 cycle after the push. busy is high for 40 cycles.
//  2. Push 0x00, then 9 pushes (0x01..0x09) on consecutive cycles during that frame.
//     -> 0x01..0x08 accepted; 0x09 dropped; overflow=1, out_full=1.
//     -> Serial output order: 0x00, 0x01 .. 0x08.
//  3. With overflow=1, assert ovf_clr and a dropped push on the same cycle.
//     -> overflow stays 1. Then ovf_clr alone -> overflow=0.
//  4. While one byte is queued, push exactly on the edge it is popped.
//     -> fifo_count unchanged. Frames go out back-to-back with a 1-cycle idle gap (41 cycles apart).
//  5. Pull rst low mid-DATA (bit 3 of 0x5A) with 3 bytes queued.
//     -> tx=1, busy=0, fifo_count=0 immediately, without waiting for a clk edge.
//     -> After release, no frame is sent until a new push.
//  6. Wrap test: push/drain 20 bytes, incrementing 0x10..0x23.
//     -> all 20 bytes are received in order, with no overflow.

Source files
------------

// File: rtl/io_out_if.sv
// CPU-side bundle of the output-port UART stage: byte push strobe, occupancy and overflow status.
interface io_out_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    out_data;
  logic          out_we;
  logic          out_full;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          ovf_clr;

  modport master (
    output out_data, out_we, ovf_clr,
    input  out_full, fifo_count, overflow
  );

  modport slave (
    input  out_data, out_we, ovf_clr,
    output out_full, fifo_count, overflow
  );
endinterface

// File: rtl/io_out_uart_tx.sv
// Output-port stage: buffers CPU OUT bytes in a small FIFO and serialises them as 8N1 UART.
// Dropped pushes (FIFO full) are flagged in a sticky overflow bit.
module io_out_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic     clk,
  input  logic     rst,
  io_out_if.slave  cpu,
  output logic     tx_o,
  output logic     busy_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic full, push, pop, baud_last;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign push      = cpu.out_we && !full;
  assign pop       = (state_q == ST_IDLE) && (count_q != '0);
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  assign cpu.out_full   = full;
  assign cpu.fifo_count = count_q;
  assign cpu.overflow   = ovf_q;
  assign tx_o           = tx_q;
  assign busy_o         = busy_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    // A dropped push wins over a simultaneous clear.
    ovf_d    = ovf_q;
    if (cpu.out_we && full) ovf_d = 1'b1;
    else if (cpu.ovf_clr)   ovf_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d = ST_START;
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            // tx is registered, so present the next bit from the pre-shift value.
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cpu.out_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end
endmodule

// File: tb/tb_io_out_uart_tx.sv
// Bench for io_out_uart_tx: frame-level reference model checked every cycle plus directed scenarios.
module tb_io_out_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int FL    = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tx, busy;
  int   tests = 0;
  int   fails = 0;

  io_out_if #(.FIFO_DEPTH(DEPTH)) bus ();

  io_out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .cpu    (bus.slave),
    .tx_o   (tx),
    .busy_o (busy)
  );

  always #5 clk = ~clk;

  // Model: a queue of accepted bytes and a countdown for the frame on the wire.
  logic [7:0] m_q[$];
  int         m_left = 0;
  logic [7:0] m_cur  = 8'h00;
  logic       m_ovf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_tx();
    int slot;
    if (m_left == 0) return 1'b1;
    slot = (FL - m_left) / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return m_cur[slot-1];
  endfunction

  task automatic tick(input logic we, input logic [7:0] d, input logic clr);
    logic pre_full, pop;
    bus.out_we   = we;
    bus.out_data = d;
    bus.ovf_clr  = clr;
    @(posedge clk);
    if (!rst) begin
      m_q.delete();
      m_left = 0;
      m_ovf  = 1'b0;
    end else begin
      pre_full = (m_q.size() == DEPTH);
      pop      = (m_left == 0) && (m_q.size() != 0);
      if (m_left > 0) m_left--;
      if (pop) begin
        m_cur  = m_q.pop_front();
        m_left = FL;
      end
      if (we && pre_full) m_ovf = 1'b1;
      else begin
        if (we) m_q.push_back(d);
        if (clr) m_ovf = 1'b0;
      end
    end
    @(negedge clk);
    chk("tx", 32'(tx), 32'(exp_tx()));
    chk("busy", 32'(busy), 32'(m_left > 0));
    chk("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
    chk("out_full", 32'(bus.out_full), 32'(m_q.size() == DEPTH));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    bus.out_we  = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_left != 0 || m_q.size() != 0) && n < 2000) begin
      tick(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("drain_done", 32'(m_left == 0 && m_q.size() == 0), 32'd1);
  endtask

  initial begin
    int nb, first_low, n, nxt;
    bus.out_we   = 1'b0;
    bus.out_data = 8'h00;
    bus.ovf_clr  = 1'b0;

    // reset state
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    chk("rst_tx", 32'(tx), 32'd1);
    rst = 1'b1;
    repeat (5) tick(1'b0, 8'h00, 1'b0);

    // 1: single byte 0xA5, latency and busy length
    tick(1'b1, 8'hA5, 1'b0);
    chk("start_not_yet", 32'(tx), 32'd1);
    nb = 0; first_low = -1;
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      if (busy) nb++;
      if (tx == 1'b0 && first_low < 0) first_low = i;
    end
    chk("busy_len", 32'(nb), 32'd40);
    chk("start_latency", 32'(first_low), 32'd0);

    // 2: burst of 10 pushes, last one dropped
    tick(1'b1, 8'h00, 1'b0);
    for (int i = 1; i <= 9; i++) tick(1'b1, 8'(i), 1'b0);
    chk("burst_ovf", 32'(bus.overflow), 32'd1);
    chk("burst_full", 32'(bus.out_full), 32'd1);

    // 3: clear colliding with a dropped push, then clear alone
    tick(1'b1, 8'hEE, 1'b1);
    chk("ovf_set_wins", 32'(bus.overflow), 32'd1);
    tick(1'b0, 8'h00, 1'b1);
    chk("ovf_cleared", 32'(bus.overflow), 32'd0);
    drain();

    // 4: push on the exact edge the only queued byte is popped
    tick(1'b1, 8'h3C, 1'b0);
    tick(1'b1, 8'hC3, 1'b0);
    n = 0;
    while (!(m_left == 0 && m_q.size() == 1) && n < 200) begin
      tick(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("pop_edge_reached", 32'(n < 200), 32'd1);
    tick(1'b1, 8'h96, 1'b0);
    chk("push_pop_count", 32'(bus.fifo_count), 32'd1);
    drain();

    // 5: async reset mid-DATA (bit 3 of 0x5A) with 3 bytes queued
    tick(1'b1, 8'h5A, 1'b0);
    tick(1'b1, 8'h11, 1'b0);
    tick(1'b1, 8'h22, 1'b0);
    tick(1'b1, 8'h33, 1'b0);
    n = 0;
    while (!(m_left > 0 && (FL - m_left) / CPB == 4) && n < 100) begin
      tick(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("bit3_reached", 32'(n < 100), 32'd1);
    chk("queued3", 32'(bus.fifo_count), 32'd3);
    #1 rst = 1'b0;
    #1;
    chk("async_tx", 32'(tx), 32'd1);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_count", 32'(bus.fifo_count), 32'd0);
    @(negedge clk);
    repeat (3) tick(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    nb = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 8'h00, 1'b0);
      if (busy || !tx) nb++;
    end
    chk("quiet_after_rst", 32'(nb), 32'd0);

    // 6: wrap test, 20 incrementing bytes
    nxt = 0; n = 0;
    while (nxt < 20 && n < 3000) begin
      if (m_q.size() < DEPTH) begin
        tick(1'b1, 8'(8'h10 + nxt), 1'b0);
        nxt++;
      end else tick(1'b0, 8'h00, 1'b0);
      n++;
    end
    chk("wrap_pushed", 32'(nxt), 32'd20);
    drain();
    chk("wrap_no_ovf", 32'(bus.overflow), 32'd0);

    // random traffic
    for (int i = 0; i < 800; i++)
      tick(($urandom % 4) == 0, 8'($urandom), ($urandom % 16) == 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
